seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001: Parameter WIDTH, default 6: operand width in bits; legal range 2..32.
REQ-002: Parameter CNT_W, default 3: multiply-counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  operand/op presented.
REQ-006: in_ready  output  1  block can accept a new operation.
REQ-007: a  input  WIDTH  operand A, unsigned (signed only for overflow flag).
REQ-008: b  input  WIDTH  operand B, same encoding as a.
REQ-009: op  input  3  000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110/111 illegal.
REQ-010: out_valid  output  1  result and flags valid.
REQ-011: out_ready  input  1  consumer takes result.
REQ-012: result  output  2*WIDTH  registered result.
REQ-013: carry  output  1  ADD carry-out / SUB borrow-out; 0 otherwise.
REQ-014: ovf  output  1  two's-complement overflow for ADD/SUB; 0 otherwise.
REQ-015: zero  output  1  result == 0.
REQ-016: err  output  1  illegal op was accepted.

Function
REQ-017: Accept = in_valid & in_ready at a rising edge; a, b, op SHALL be captured only on accept.
REQ-018: FSM states IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019: IDLE + accept of non-MUL op -> DONE; result/flags registered on that same edge; out_valid = 1 after 1 edge.
REQ-020: IDLE + accept of MUL -> MUL; counter loaded with 0, accumulator cleared.
REQ-021: MUL: one shift-add step per cycle (bit i of b adds a<<i); after exactly WIDTH steps -> DONE; out_valid after WIDTH+1 edges from accept.
REQ-022: DONE: result, flags, out_valid SHALL hold stable until out_valid & out_ready; on that edge -> IDLE, out_valid = 0.
REQ-023: No new accept in the same cycle as a DONE handshake; throughput is at most one op per 2 cycles.
REQ-024: ADD/SUB/AND/OR/XOR: result = zero-extended WIDTH-bit value; upper WIDTH bits = 0.
REQ-025: ADD: carry = bit WIDTH of a+b; ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
REQ-026: SUB: result = (a-b) mod 2**WIDTH; carry = 1 when a<b unsigned; ovf = (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]).
REQ-027: MUL: result = full 2*WIDTH unsigned product; carry = ovf = 0.
REQ-028: Illegal op: treated as single-cycle; result = 0, zero = 1, err = 1, carry = ovf = 0.
REQ-029: zero computed over full 2*WIDTH result; err = 0 for legal ops.
REQ-030: out_ready while out_valid = 0 SHALL have no effect; in_valid while in_ready = 0 SHALL be ignored.

Reset
REQ-031: rst_n low SHALL immediately (asynchronously) force IDLE, in_ready = 1, out_valid = 0, result = 0, carry = ovf = err = 0, zero = 1, counter/accumulator = 0.
REQ-032: Reset during MUL or DONE SHALL abandon the operation; no out_valid follows reset release without a new accept.
REQ-033: First accept possible on the first rising edge with rst_n high.

Verification (WIDTH = 6)
REQ-034: ADD a=63, b=1, out_ready=1 -> next cycle out_valid=1, result=0x000, carry=1, zero=1, ovf=0.
REQ-035: SUB a=5, b=6 -> result=0x03F, carry=1, ovf=0; SUB a=32, b=1 -> result=0x01F, ovf=1.
REQ-036: MUL a=63, b=63 -> out_valid first high 7 edges after accept, result=0xF81 (3969), in_ready=0 throughout.
REQ-037: Backpressure: XOR a=0x2A, b=0x15, out_ready=0 for 5 cycles -> result=0x03F held stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-038: Reset asserted 3 cycles into MUL -> outputs at reset values immediately; after release no out_valid until new accept.
REQ-039: op=111, a=9, b=9 -> result=0, zero=1, err=1; following legal AND a=9, b=3 -> result=0x001, err=0.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: an input valid/ready channel and an output valid/ready channel.
interface seq_alu_if #(
    parameter int WIDTH = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         op;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               carry;
    logic               ovf;
    logic               zero;
    logic               err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, ovf, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, ovf, zero, err
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic ops and a WIDTH-step shift-add multiply.
// The result and flags are held until the consumer takes them.
//   state | meaning
//   IDLE  | ready to accept a new operation
//   MUL   | one shift-add step per cycle, WIDTH steps in total
//   DONE  | result valid, held until out_ready
module seq_alu #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input logic    clk,
    input logic    rst_n,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic [2*WIDTH-1:0]   acc_step;

    assign sum_w    = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w   = {1'b0, bus.a} - {1'b0, bus.b};
    assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, bus.a};
                        mplr_d  = bus.b;
                    end else begin
                        state_d  = DONE;
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b0;
                        result_d = '0;
                        case (bus.op)
                            OP_ADD: begin
                                result_d = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
                                carry_d  = sum_w[WIDTH];
                                ovf_d    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                           (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
                            end
                            OP_SUB: begin
                                result_d = {{WIDTH{1'b0}}, diff_w[WIDTH-1:0]};
                                carry_d  = diff_w[WIDTH];
                                ovf_d    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                           (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
                            end
                            OP_AND:  result_d = {{WIDTH{1'b0}}, bus.a & bus.b};
                            OP_OR:   result_d = {{WIDTH{1'b0}}, bus.a | bus.b};
                            OP_XOR:  result_d = {{WIDTH{1'b0}}, bus.a ^ bus.b};
                            default: err_d    = 1'b1;
                        endcase
                        zero_d = (result_d == '0);
                    end
                end
            end
            MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // the final step's sum goes straight into the result register
                if (cnt_q == LAST_STEP) begin
                    state_d  = DONE;
                    result_d = acc_step;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    zero_d   = (acc_step == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu, checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 6;
    localparam int M = 1 << W;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic void model(input int opc, input int ia, input int ib,
                                  output longint res, output bit c, output bit v,
                                  output bit z, output bit e);
        int s;
        res = 0; c = 0; v = 0; e = 0;
        case (opc)
            0: begin
                res = (ia + ib) % M;
                c   = (ia + ib) >= M;
                s   = to_signed(ia) + to_signed(ib);
                v   = (s > M / 2 - 1) || (s < -(M / 2));
            end
            1: begin
                res = (ia - ib + M) % M;
                c   = ia < ib;
                s   = to_signed(ia) - to_signed(ib);
                v   = (s > M / 2 - 1) || (s < -(M / 2));
            end
            2: res = longint'(ia) * longint'(ib);
            3: res = ia & ib;
            4: res = ia | ib;
            5: res = ia ^ ib;
            default: e = 1;
        endcase
        z = (res == 0);
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_result"},    64'(bus.result), 64'd0);
        chk({tag, "_flags"},     64'({bus.carry, bus.ovf, bus.err, bus.zero}), 64'b0001);
    endtask

    // One full transaction: accept, latency, result/flags, optional backpressure, handshake.
    task automatic do_op(input int opc, input int ia, input int ib, input int hold, input bit early);
        longint er;
        bit ec, ev, ez, ee;
        int lat;
        int exp_lat;
        model(opc, ia, ib, er, ec, ev, ez, ee);
        exp_lat = (opc == 2) ? W + 1 : 1;
        @(negedge clk);
        chk("ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.op        = 3'(opc);
        bus.a         = W'(ia);
        bus.b         = W'(ib);
        bus.out_ready = early;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom_range(0, M - 1));
        bus.b        = W'($urandom_range(0, M - 1));
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            chk("ready_busy", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", 64'(bus.result), 64'(er));
        chk("carry", 64'(bus.carry), 64'(ec));
        chk("ovf", 64'(bus.ovf), 64'(ev));
        chk("zero", 64'(bus.zero), 64'(ez));
        chk("err", 64'(bus.err), 64'(ee));
        chk("ready_done", 64'(bus.in_ready), 64'd0);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.op       = 3'($urandom_range(0, 7));
                @(posedge clk);
                #1;
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_ready", 64'(bus.in_ready), 64'd0);
                chk("hold_result", 64'(bus.result), 64'(er));
                chk("hold_flags", 64'({bus.carry, bus.ovf, bus.zero, bus.err}),
                    64'({ec, ev, ez, ee}));
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("released", 64'(bus.out_valid), 64'd0);
        chk("ready_after", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        rst_n         = 1'b0;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 63, 1, 0, 1'b1);
        do_op(1, 5, 6, 0, 1'b0);
        do_op(1, 32, 1, 1, 1'b0);
        do_op(2, 63, 63, 0, 1'b1);
        do_op(2, 0, 45, 2, 1'b0);
        do_op(5, 'h2A, 'h15, 5, 1'b0);
        do_op(7, 9, 9, 0, 1'b0);
        do_op(3, 9, 3, 0, 1'b0);
        do_op(6, 1, 2, 1, 1'b1);

        // abandon a multiply partway through with an asynchronous reset
        do_op(5, 'h2A, 'h15, 0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 3'd2;
        bus.a        = W'(63);
        bus.b        = W'(63);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_mul_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("no_valid_after_rst", 64'(bus.out_valid), 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            do_op($urandom_range(0, 7), $urandom_range(0, M - 1), $urandom_range(0, M - 1),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
